hazard_ctrl_dual: RTL and testbench



---
 rtl/hazard_ctrl_dual_pkg.sv | 51 +++++
 rtl/hazard_ctrl_dual_if.sv | 34 +++
 rtl/hazard_ctrl_dual_fwd_select.sv | 33 +++
 rtl/hazard_ctrl_dual.sv | 103 ++++++++++
 tb/tb_hazard_ctrl_dual.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_dual_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared types and helpers for the dual-lane hazard controller.
// Revision : 1.0
// ============================================================================
package hazard_pkg;

    localparam int NREG = 32;
    localparam int RW   = $clog2(NREG);
    localparam logic [RW-1:0] REG_ZERO = '0;

    // Bits [1:0] line up with the legacy lane-A 2-bit mux; bit 2 selects lane B.
    typedef enum logic [2:0] {
        FWD_RF  = 3'b000,
        FWD_A_W = 3'b001,
        FWD_A_M = 3'b010,
        FWD_B_W = 3'b101,
        FWD_B_M = 3'b110
    } fwd_sel_t;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          regwrite;
        logic          load;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
    } stage_tag_t;

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          regwrite;
    } wb_tag_t;

    function automatic wb_tag_t to_wb(input stage_tag_t t);
        return '{valid: t.valid, rd: t.rd, regwrite: t.regwrite};
    endfunction

    function automatic logic fwd_hit(input wb_tag_t t, input logic [RW-1:0] rs);
        return t.valid && t.regwrite && (t.rd == rs) && (rs != REG_ZERO);
    endfunction

    function automatic logic load_use(input stage_tag_t e, input stage_tag_t d);
        return e.valid && e.load && (e.rd != REG_ZERO) && d.valid &&
               ((e.rd == d.rs1) || (e.rd == d.rs2));
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_dual_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_dual_if
// Brief    : D-stage decode info in, forward selects and pipeline controls out.
// Revision : 1.0
// ============================================================================
interface hazard_ctrl_dual_if;
    import hazard_pkg::*;

    logic          ValidA_D, ValidB_D;
    logic [RW-1:0] Rs1A_D, Rs2A_D, Rs1B_D, Rs2B_D;
    logic [RW-1:0] RdA_D, RdB_D;
    logic          RegWriteA_D, RegWriteB_D;
    logic          LoadA_D, LoadB_D;
    logic          PCSrc_E;
    logic [2:0]    ForwardA1_E, ForwardA2_E, ForwardB1_E, ForwardB2_E;
    logic          StallF, StallD, FlushD, FlushE;

    modport master (
        output ValidA_D, ValidB_D, Rs1A_D, Rs2A_D, Rs1B_D, Rs2B_D,
               RdA_D, RdB_D, RegWriteA_D, RegWriteB_D, LoadA_D, LoadB_D, PCSrc_E,
        input  ForwardA1_E, ForwardA2_E, ForwardB1_E, ForwardB2_E,
               StallF, StallD, FlushD, FlushE
    );

    modport slave (
        input  ValidA_D, ValidB_D, Rs1A_D, Rs2A_D, Rs1B_D, Rs2B_D,
               RdA_D, RdB_D, RegWriteA_D, RegWriteB_D, LoadA_D, LoadB_D, PCSrc_E,
        output ForwardA1_E, ForwardA2_E, ForwardB1_E, ForwardB2_E,
               StallF, StallD, FlushD, FlushE
    );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_dual_fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Brief    : Priority forward select for one E-stage source register.
// Revision : 1.0
// ============================================================================
module fwd_select
    import hazard_pkg::*;
(
    input  logic [RW-1:0] i_rs,
    input  wb_tag_t       i_a_m,
    input  wb_tag_t       i_b_m,
    input  wb_tag_t       i_a_w,
    input  wb_tag_t       i_b_w,
    output fwd_sel_t      o_sel
);

    // Newest producer wins; lane B is younger than lane A within a pair.
    always_comb begin
        o_sel = FWD_RF;
        if (fwd_hit(i_b_m, i_rs)) begin
            o_sel = FWD_B_M;
        end else if (fwd_hit(i_a_m, i_rs)) begin
            o_sel = FWD_A_M;
        end else if (fwd_hit(i_b_w, i_rs)) begin
            o_sel = FWD_B_W;
        end else if (fwd_hit(i_a_w, i_rs)) begin
            o_sel = FWD_A_W;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_dual.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_dual
// Brief    : Dual-lane forwarding, load-use stall and branch flush control.
//            Define HAZ_PERF_CNT_EN to add StallCnt/FlushCnt counters.
// Revision : 1.0
// ============================================================================
module hazard_ctrl_dual
    import hazard_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    hazard_ctrl_dual_if.slave  bus
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]        StallCnt,
    output logic [31:0]        FlushCnt
`endif
);

    stage_tag_t r_a_e, r_b_e;
    wb_tag_t    r_a_m, r_b_m, r_a_w, r_b_w;
    stage_tag_t w_a_d, w_b_d;
    logic       w_lw_stall, w_stall, w_flush_e;
    fwd_sel_t   w_fa1, w_fa2, w_fb1, w_fb2;

    assign w_a_d = '{valid: bus.ValidA_D, rd: bus.RdA_D, regwrite: bus.RegWriteA_D,
                     load: bus.LoadA_D, rs1: bus.Rs1A_D, rs2: bus.Rs2A_D};
    assign w_b_d = '{valid: bus.ValidB_D, rd: bus.RdB_D, regwrite: bus.RegWriteB_D,
                     load: bus.LoadB_D, rs1: bus.Rs1B_D, rs2: bus.Rs2B_D};

    assign w_lw_stall = load_use(r_a_e, w_a_d) || load_use(r_a_e, w_b_d) ||
                        load_use(r_b_e, w_a_d) || load_use(r_b_e, w_b_d);

    // A taken redirect discards the stalled D instruction, so the stall is dropped.
    assign w_stall   = w_lw_stall && !bus.PCSrc_E && !reset;
    assign w_flush_e = (w_stall || bus.PCSrc_E) && !reset;

    assign bus.StallF = w_stall;
    assign bus.StallD = w_stall;
    assign bus.FlushD = bus.PCSrc_E && !reset;
    assign bus.FlushE = w_flush_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_e <= '0;
            r_b_e <= '0;
            r_a_m <= '0;
            r_b_m <= '0;
            r_a_w <= '0;
            r_b_w <= '0;
        end else begin
            if (w_flush_e) begin
                r_a_e.valid <= 1'b0;
                r_b_e.valid <= 1'b0;
            end else begin
                r_a_e <= w_a_d;
                r_b_e <= w_b_d;
            end
            r_a_m <= to_wb(r_a_e);
            r_b_m <= to_wb(r_b_e);
            r_a_w <= r_a_m;
            r_b_w <= r_b_m;
        end
    end

    fwd_select u_fwd_a1 (.i_rs(r_a_e.rs1), .i_a_m(r_a_m), .i_b_m(r_b_m),
                         .i_a_w(r_a_w), .i_b_w(r_b_w), .o_sel(w_fa1));
    fwd_select u_fwd_a2 (.i_rs(r_a_e.rs2), .i_a_m(r_a_m), .i_b_m(r_b_m),
                         .i_a_w(r_a_w), .i_b_w(r_b_w), .o_sel(w_fa2));
    fwd_select u_fwd_b1 (.i_rs(r_b_e.rs1), .i_a_m(r_a_m), .i_b_m(r_b_m),
                         .i_a_w(r_a_w), .i_b_w(r_b_w), .o_sel(w_fb1));
    fwd_select u_fwd_b2 (.i_rs(r_b_e.rs2), .i_a_m(r_a_m), .i_b_m(r_b_m),
                         .i_a_w(r_a_w), .i_b_w(r_b_w), .o_sel(w_fb2));

    assign bus.ForwardA1_E = w_fa1;
    assign bus.ForwardA2_E = w_fa2;
    assign bus.ForwardB1_E = w_fb1;
    assign bus.ForwardB2_E = w_fb2;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (bus.PCSrc_E && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign StallCnt = r_stall_cnt;
    assign FlushCnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_dual.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl_dual
// Brief    : Directed scoreboard bench for hazard_ctrl_dual (HAZ_PERF_CNT_EN aware).
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl_dual;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } lane_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    logic [15:0] q_exp[$];
    string       q_tag[$];
    logic [15:0] m_exp;
    string       m_tag;

    hazard_ctrl_dual_if bus ();

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    hazard_ctrl_dual dut (.clk(clk), .reset(reset), .bus(bus),
                          .StallCnt(stall_cnt), .FlushCnt(flush_cnt));
`else
    hazard_ctrl_dual dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic lane_t nop();
        return '0;
    endfunction

    function automatic lane_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return '{v: 1'b1, rs1: rs1, rs2: rs2, rd: rd, rw: 1'b1, ld: 1'b0};
    endfunction

    function automatic lane_t lw(input logic [4:0] rd, input logic [4:0] rs1);
        return '{v: 1'b1, rs1: rs1, rs2: 5'd0, rd: rd, rw: 1'b1, ld: 1'b1};
    endfunction

    // Packed expectation: {fa1, fa2, fb1, fb2, stallf, stalld, flushd, flushe}
    function automatic logic [15:0] ex(input logic [2:0] fa1, input logic [2:0] fa2,
                                       input logic [2:0] fb1, input logic [2:0] fb2,
                                       input logic sf, input logic sd,
                                       input logic fd, input logic fe);
        return {fa1, fa2, fb1, fb2, sf, sd, fd, fe};
    endfunction

    localparam logic [15:0] c_z     = 16'h0000;
    localparam logic [15:0] c_stall = 16'b000_000_000_000_1101;
    localparam logic [15:0] c_redir = 16'b000_000_000_000_0011;

    task automatic drive(input string tag, input lane_t a, input lane_t b, input logic pc,
                         input logic [15:0] exp, input logic push);
        bus.ValidA_D    = a.v;   bus.ValidB_D    = b.v;
        bus.Rs1A_D      = a.rs1; bus.Rs1B_D      = b.rs1;
        bus.Rs2A_D      = a.rs2; bus.Rs2B_D      = b.rs2;
        bus.RdA_D       = a.rd;  bus.RdB_D       = b.rd;
        bus.RegWriteA_D = a.rw;  bus.RegWriteB_D = b.rw;
        bus.LoadA_D     = a.ld;  bus.LoadB_D     = b.ld;
        bus.PCSrc_E     = pc;
        if (push) begin
            q_exp.push_back(exp);
            q_tag.push_back(tag);
        end
    endtask

    task automatic step(input string tag, input lane_t a, input lane_t b, input logic pc,
                        input logic [15:0] exp);
        @(posedge clk);
        #1;
        drive(tag, a, b, pc, exp, 1'b1);
    endtask

    always @(negedge clk) begin
        if (q_exp.size() > 0) begin
            m_exp = q_exp.pop_front();
            m_tag = q_tag.pop_front();
            chk_val({m_tag, ".fa1"},    {29'd0, bus.ForwardA1_E}, {29'd0, m_exp[15:13]});
            chk_val({m_tag, ".fa2"},    {29'd0, bus.ForwardA2_E}, {29'd0, m_exp[12:10]});
            chk_val({m_tag, ".fb1"},    {29'd0, bus.ForwardB1_E}, {29'd0, m_exp[9:7]});
            chk_val({m_tag, ".fb2"},    {29'd0, bus.ForwardB2_E}, {29'd0, m_exp[6:4]});
            chk_val({m_tag, ".stallf"}, {31'd0, bus.StallF},      {31'd0, m_exp[3]});
            chk_val({m_tag, ".stalld"}, {31'd0, bus.StallD},      {31'd0, m_exp[2]});
            chk_val({m_tag, ".flushd"}, {31'd0, bus.FlushD},      {31'd0, m_exp[1]});
            chk_val({m_tag, ".flushe"}, {31'd0, bus.FlushE},      {31'd0, m_exp[0]});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        drive("init", nop(), nop(), 1'b0, c_z, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Idle after reset
        step("idle0", nop(), nop(), 1'b0, c_z);
        step("idle1", nop(), nop(), 1'b0, c_z);

        // ALU forward from M then W
        step("add5",    alu(5'd5, 5'd1, 5'd2), nop(),                  1'b0, c_z);
        step("rdB1",    nop(),                  alu(5'd9, 5'd5, 5'd0),  1'b0, c_z);
        step("fwdB1_M", nop(),                  alu(5'd10, 5'd0, 5'd5), 1'b0, ex(3'b000, 3'b000, 3'b010, 3'b000, 0, 0, 0, 0));
        step("fwdB2_W", nop(),                  nop(),                  1'b0, ex(3'b000, 3'b000, 3'b000, 3'b001, 0, 0, 0, 0));
        step("gap0",    nop(),                  nop(),                  1'b0, c_z);

        // Both lanes write x7: lane B wins
        step("dual7",   alu(5'd7, 5'd0, 5'd0),  alu(5'd7, 5'd0, 5'd0),  1'b0, c_z);
        step("rd7",     alu(5'd11, 5'd7, 5'd0), nop(),                  1'b0, c_z);
        step("fwdA1_BM", nop(),                 nop(),                  1'b0, ex(3'b110, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
        step("gap1",    nop(),                  nop(),                  1'b0, c_z);

        // Load-use on lane B rs2
        step("lw3",     lw(5'd3, 5'd0),         nop(),                  1'b0, c_z);
        step("lu_stall", nop(),                 alu(5'd12, 5'd0, 5'd3), 1'b0, c_stall);
        step("lu_hold", nop(),                  alu(5'd12, 5'd0, 5'd3), 1'b0, c_z);
        step("lu_fwdW", nop(),                  nop(),                  1'b0, ex(3'b000, 3'b000, 3'b000, 3'b001, 0, 0, 0, 0));

        // Load-use coincident with a taken redirect
        step("lw4",     lw(5'd4, 5'd0),         nop(),                  1'b0, c_z);
        step("lu_redir", alu(5'd13, 5'd4, 5'd0), nop(),                 1'b1, c_redir);
        step("post_redir", nop(),               nop(),                  1'b0, c_z);

        // x0 is never forwarded and never stalls
        step("wr_x0",   alu(5'd0, 5'd0, 5'd0),  alu(5'd0, 5'd0, 5'd0),  1'b0, c_z);
        step("rd_x0",   alu(5'd15, 5'd0, 5'd0), alu(5'd16, 5'd0, 5'd0), 1'b0, c_z);
        step("fwd_x0",  nop(),                  nop(),                  1'b0, c_z);
        step("lw_x0",   lw(5'd0, 5'd0),         nop(),                  1'b0, c_z);
        step("lu_x0",   nop(),                  alu(5'd17, 5'd0, 5'd0), 1'b0, c_z);
        step("gap2",    nop(),                  nop(),                  1'b0, c_z);

        // Lane B load feeding lane A, twice
        step("lwB6",    nop(),                  lw(5'd6, 5'd0),         1'b0, c_z);
        step("luB6",    alu(5'd14, 5'd0, 5'd6), nop(),                  1'b0, c_stall);
        step("luB6_hold", alu(5'd14, 5'd0, 5'd6), nop(),                1'b0, c_z);
        step("fwdA2_BW", nop(),                 nop(),                  1'b0, ex(3'b000, 3'b101, 3'b000, 3'b000, 0, 0, 0, 0));
        step("lwB8",    nop(),                  lw(5'd8, 5'd0),         1'b0, c_z);
        step("luB8",    alu(5'd18, 5'd8, 5'd0), nop(),                  1'b0, c_stall);
        step("luB8_hold", alu(5'd18, 5'd8, 5'd0), nop(),                1'b0, c_z);
        step("fwdA1_BW", nop(),                 nop(),                  1'b0, ex(3'b101, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0));
        step("gap3",    nop(),                  nop(),                  1'b0, c_z);
        @(negedge clk);
        #1;
`ifdef HAZ_PERF_CNT_EN
        chk_val("stall_cnt", stall_cnt, 32'd3);
        chk_val("flush_cnt", flush_cnt, 32'd1);
`endif

        // Reset during a load-use stall discards the load entirely
        step("lw9", lw(5'd9, 5'd0), nop(), 1'b0, c_z);
        @(posedge clk);
        #1;
        drive("lu9_rst", nop(), alu(5'd19, 5'd0, 5'd9), 1'b0, c_z, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive("rst_hold", nop(), alu(5'd19, 5'd0, 5'd9), 1'b0, c_z, 1'b1);
        @(negedge clk);
        #1;
`ifdef HAZ_PERF_CNT_EN
        chk_val("stall_cnt_rst", stall_cnt, 32'd0);
        chk_val("flush_cnt_rst", flush_cnt, 32'd0);
`endif
        step("rst_no_fwd", nop(), nop(), 1'b0, c_z);
        step("tail",       nop(), nop(), 1'b0, c_z);
        @(negedge clk);
        #1;

        if (q_exp.size() != 0) begin
            chk_val("queue_drain", q_exp.size(), 32'd0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
